// File: rtl/stage5_ctrl_pkg.sv
// Shared types and default widths for the stage-5 sequencer and its lane registers.
package stage5_ctrl_pkg;

  localparam int unsigned DEF_PARALLEL_SIZE = 2;
  localparam int unsigned DEF_INTERVAL_SIZE = 8;
  localparam int unsigned DEF_PARA          = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [DEF_PARALLEL_SIZE-1:0][DEF_INTERVAL_SIZE-1:0][DEF_PARA-1:0] hist_t;
  typedef logic [DEF_PARALLEL_SIZE-1:0][DEF_PARA-1:0]                        cnt_t;
  typedef logic [DEF_PARALLEL_SIZE-1:0][DEF_INTERVAL_SIZE-1:0]               mode_t;

endpackage

// File: rtl/stage5_lane_regs.sv
// One lane of stage-5 state: interval bins, max count and one-hot mode.
module stage5_lane_regs
  import stage5_ctrl_pkg::*;
#(
  parameter int unsigned INTERVAL_SIZE = DEF_INTERVAL_SIZE,
  parameter int unsigned PARA          = DEF_PARA
) (
  input  logic                          CLK_i,
  input  logic                          RST_i,
  input  logic                          clear_i,
  input  logic                          commit_i,
  input  logic                          u_add_i,
  input  logic [INTERVAL_SIZE*PARA-1:0] cnt_nxt_i,
  input  logic [PARA-1:0]               max_nxt_i,
  input  logic [INTERVAL_SIZE-1:0]      mode_nxt_i,
  output logic [INTERVAL_SIZE*PARA-1:0] cnt_q_o,
  output logic [PARA-1:0]               max_q_o,
  output logic [INTERVAL_SIZE-1:0]      mode_q_o
);

  // A counter already at all-ones whose next value wrapped to zero stays pinned.
  function automatic logic [PARA-1:0] sat_upd(input logic [PARA-1:0] q, input logic [PARA-1:0] nxt);
    return ((&q) && (nxt == '0)) ? q : nxt;
  endfunction

  // Clear on job start, commit on accepted beats, otherwise hold.
  always_ff @(posedge CLK_i) begin
    if (RST_i || clear_i) begin
      cnt_q_o  <= '0;
      max_q_o  <= '0;
      mode_q_o <= '0;
    end else if (commit_i) begin
      for (int unsigned i = 0; i < INTERVAL_SIZE; i++) begin
        cnt_q_o[i*PARA +: PARA] <= sat_upd(cnt_q_o[i*PARA +: PARA], cnt_nxt_i[i*PARA +: PARA]);
      end
      if (u_add_i) begin
        max_q_o  <= sat_upd(max_q_o, max_nxt_i);
        mode_q_o <= mode_nxt_i;
      end
    end
  end

endmodule

// File: rtl/stage5_seq_ctrl.sv
// Job sequencer for the stage-5 datapath: start/busy/done handshake, beat counting
// and ownership of the per-lane histogram/max/mode registers.
module stage5_seq_ctrl
  import stage5_ctrl_pkg::*;
#(
  parameter int unsigned PARALLEL_SIZE = DEF_PARALLEL_SIZE,
  parameter int unsigned INTERVAL_SIZE = DEF_INTERVAL_SIZE,
  parameter int unsigned PARA          = DEF_PARA
) (
  input  logic                                        CLK_i,
  input  logic                                        RST_i,
  input  logic                                        start_i,
  input  logic                                        abort_i,
  input  logic [PARA-1:0]                             j_size_i,
  output logic                                        busy_o,
  output logic                                        done_o,
  input  logic                                        in_valid_i,
  output logic                                        in_ready_o,
  output logic                                        beat_o,
  output logic [PARA-1:0]                             beat_cnt_o,
  input  logic [PARALLEL_SIZE*INTERVAL_SIZE*PARA-1:0] interval_cnt_nxt_i,
  input  logic [PARALLEL_SIZE*PARA-1:0]               max_cnt_nxt_i,
  input  logic [PARALLEL_SIZE*INTERVAL_SIZE-1:0]      mode_nxt_i,
  input  logic [PARALLEL_SIZE-1:0]                    u_add_i,
  output logic [PARALLEL_SIZE*INTERVAL_SIZE*PARA-1:0] interval_cnt_q_o,
  output logic [PARALLEL_SIZE*PARA-1:0]               max_cnt_q_o,
  output logic [PARALLEL_SIZE*INTERVAL_SIZE-1:0]      mode_q_o
);

  localparam int unsigned LANE_HIST_W = INTERVAL_SIZE * PARA;

  state_e          state_q, state_d;
  logic [PARA-1:0] j_q;
  logic [PARA-1:0] beat_cnt_q;
  logic            load_j_c;
  logic            clear_c;
  logic            commit_c;
  logic            last_c;

  // State register.
  always_ff @(posedge CLK_i) begin
    if (RST_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and control strobes; abort overrides everything outside IDLE.
  always_comb begin
    state_d    = state_q;
    load_j_c   = 1'b0;
    clear_c    = 1'b0;
    commit_c   = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    in_ready_o = 1'b0;
    last_c     = (beat_cnt_q == PARA'(j_q - PARA'(1)));
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load_j_c = 1'b1;
          state_d  = (j_size_i != '0) ? CLEAR : DONE;
        end
      end
      CLEAR: begin
        busy_o  = 1'b1;
        clear_c = ~abort_i;
        state_d = RUN;
      end
      RUN: begin
        busy_o     = 1'b1;
        in_ready_o = 1'b1;
        if (in_valid_i && !abort_i) begin
          commit_c = 1'b1;
          if (last_c) state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_i && (state_q != IDLE)) state_d = IDLE;
  end

  assign beat_o     = in_valid_i & in_ready_o;
  assign beat_cnt_o = beat_cnt_q;

  // Job length latch and accepted-beat counter.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      j_q        <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (load_j_c) j_q <= j_size_i;
      if (clear_c)       beat_cnt_q <= '0;
      else if (commit_c) beat_cnt_q <= beat_cnt_q + PARA'(1);
    end
  end

  for (genvar p = 0; p < PARALLEL_SIZE; p++) begin : g_lane
    stage5_lane_regs #(
      .INTERVAL_SIZE (INTERVAL_SIZE),
      .PARA          (PARA)
    ) u_lane (
      .CLK_i      (CLK_i),
      .RST_i      (RST_i),
      .clear_i    (clear_c),
      .commit_i   (commit_c),
      .u_add_i    (u_add_i[p]),
      .cnt_nxt_i  (interval_cnt_nxt_i[p*LANE_HIST_W +: LANE_HIST_W]),
      .max_nxt_i  (max_cnt_nxt_i[p*PARA +: PARA]),
      .mode_nxt_i (mode_nxt_i[p*INTERVAL_SIZE +: INTERVAL_SIZE]),
      .cnt_q_o    (interval_cnt_q_o[p*LANE_HIST_W +: LANE_HIST_W]),
      .max_q_o    (max_cnt_q_o[p*PARA +: PARA]),
      .mode_q_o   (mode_q_o[p*INTERVAL_SIZE +: INTERVAL_SIZE])
    );
  end

endmodule

// File: tb/tb_stage5_seq_ctrl.sv
// Self-checking bench for stage5_seq_ctrl: directed table, hand sequences, random vs model.
module tb_stage5_seq_ctrl;
  import stage5_ctrl_pkg::*;

  localparam int unsigned P  = DEF_PARALLEL_SIZE;
  localparam int unsigned I  = DEF_INTERVAL_SIZE;
  localparam int unsigned W  = DEF_PARA;
  localparam int unsigned HW = P * I * W;

  logic            clk;
  logic            rst, start, abort, in_valid;
  logic [W-1:0]    jsz;
  logic            busy, done, ready, beat;
  logic [W-1:0]    bcnt;
  logic [HW-1:0]   hn, hq;
  logic [P*W-1:0]  mn, mq;
  logic [P*I-1:0]  mo, moq;
  logic [P-1:0]    ua;

  stage5_seq_ctrl dut (
    .CLK_i              (clk),
    .RST_i              (rst),
    .start_i            (start),
    .abort_i            (abort),
    .j_size_i           (jsz),
    .busy_o             (busy),
    .done_o             (done),
    .in_valid_i         (in_valid),
    .in_ready_o         (ready),
    .beat_o             (beat),
    .beat_cnt_o         (bcnt),
    .interval_cnt_nxt_i (hn),
    .max_cnt_nxt_i      (mn),
    .mode_nxt_i         (mo),
    .u_add_i            (ua),
    .interval_cnt_q_o   (hq),
    .max_cnt_q_o        (mq),
    .mode_q_o           (moq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: job progress tracked as flags plus counts.
  logic [W-1:0] m_hist [P][I];
  logic [W-1:0] m_max  [P];
  logic [I-1:0] m_mode [P];
  logic [W-1:0] m_j, m_cnt;
  bit m_active, m_clear, m_done, m_known;

  function automatic logic [W-1:0] sat(input logic [W-1:0] q, input logic [W-1:0] n);
    return (q == {W{1'b1}} && n == '0) ? q : n;
  endfunction

  task automatic model_zero_data();
    for (int p = 0; p < P; p++) begin
      for (int i = 0; i < I; i++) m_hist[p][i] = '0;
      m_max[p]  = '0;
      m_mode[p] = '0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_active = 0; m_clear = 0; m_done = 0; m_known = 1;
      m_j = '0; m_cnt = '0;
      model_zero_data();
    end else if (abort && (m_active || m_done)) begin
      m_active = 0; m_clear = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start) begin
        m_j = jsz;
        if (jsz == '0) m_done = 1;
        else begin m_active = 1; m_clear = 1; end
      end
    end else if (m_clear) begin
      model_zero_data();
      m_cnt = '0;
      m_clear = 0;
    end else if (in_valid) begin
      for (int p = 0; p < P; p++) begin
        for (int i = 0; i < I; i++)
          m_hist[p][i] = sat(m_hist[p][i], hn[(p*I+i)*W +: W]);
        if (ua[p]) begin
          m_max[p]  = sat(m_max[p], mn[p*W +: W]);
          m_mode[p] = mo[p*I +: I];
        end
      end
      m_cnt = m_cnt + W'(1);
      if (m_cnt == m_j) begin m_active = 0; m_done = 1; end
    end
  endtask

  task automatic model_check();
    logic [HW-1:0]  eh;
    logic [P*W-1:0] em;
    logic [P*I-1:0] emo;
    bit             er;
    for (int p = 0; p < P; p++) begin
      for (int i = 0; i < I; i++) eh[(p*I+i)*W +: W] = m_hist[p][i];
      em[p*W +: W]  = m_max[p];
      emo[p*I +: I] = m_mode[p];
    end
    er = m_active && !m_clear;
    chk("m_busy",  HW'(busy),  HW'(m_active));
    chk("m_done",  HW'(done),  HW'(m_done));
    chk("m_ready", HW'(ready), HW'(er));
    chk("m_beat",  HW'(beat),  HW'(in_valid & er));
    chk("m_cnt",   HW'(bcnt),  HW'(m_cnt));
    chk("m_hist",  hq,         eh);
    chk("m_max",   HW'(mq),    HW'(em));
    chk("m_mode",  HW'(moq),   HW'(emo));
  endtask

  // Drive one cycle's inputs after the falling edge and check outputs against the model.
  task automatic drive(input logic r, input logic s, input logic a, input logic v,
                       input logic [W-1:0] j, input logic [HW-1:0] h, input logic [P*W-1:0] m,
                       input logic [P*I-1:0] md, input logic [P-1:0] u);
    @(negedge clk);
    rst = r; start = s; abort = a; in_valid = v; jsz = j;
    hn = h; mn = m; mo = md; ua = u;
    #1;
    if (m_known) model_check();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    advance();
  endtask

  function automatic logic [W-1:0] rbin();
    int unsigned k;
    k = $urandom_range(0, 3);
    if (k == 0) return '0;
    if (k == 1) return '1;
    return W'($urandom());
  endfunction

  function automatic logic [HW-1:0] rhist(input bit nonzero);
    logic [HW-1:0] h;
    for (int b = 0; b < int'(P*I); b++)
      h[b*W +: W] = nonzero ? (W'($urandom()) | W'(1)) : rbin();
    return h;
  endfunction

  function automatic logic [P*W-1:0] rmax();
    logic [P*W-1:0] m;
    for (int p = 0; p < P; p++) m[p*W +: W] = rbin();
    return m;
  endfunction

  typedef struct {
    logic         start, abort, valid;
    logic [W-1:0] j;
    logic         busy, done, ready;
    logic [W-1:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic a, input logic v, input int j,
                              input logic b, input logic d, input logic r, input int c);
    vec_t t;
    t.start = s; t.abort = a; t.valid = v; t.j = W'(j);
    t.busy = b; t.done = d; t.ready = r; t.cnt = W'(c);
    return t;
  endfunction

  vec_t tbl [20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [HW-1:0] last_h;
    int            nbeats;
    bit            seen;

    // J=3 with valid held, then J=0, then abort at beat 2 of 5 followed by J=1.
    tbl[0]  = mk(1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1);
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 2);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 3);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 3);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 3);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3);
    tbl[10] = mk(1'b1, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0, 3);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 3);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 0);
    tbl[13] = mk(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1);
    tbl[14] = mk(1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 2);
    tbl[15] = mk(1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 2);
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 2);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 0);
    tbl[18] = mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1);
    tbl[19] = mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1);

    m_known = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; jsz = '0;
    hn = '0; mn = '0; mo = '0; ua = '0;

    // Reset, then confirm the reset state explicitly.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, W'(7), rhist(1'b0), rmax(), P*I'($urandom()), P'($urandom()));
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    chk("rst_busy",  HW'(busy),  '0);
    chk("rst_done",  HW'(done),  '0);
    chk("rst_ready", HW'(ready), '0);
    chk("rst_cnt",   HW'(bcnt),  '0);
    chk("rst_hist",  hq,         '0);
    chk("rst_max",   HW'(mq),    '0);
    chk("rst_mode",  HW'(moq),   '0);
    advance();

    // Directed table.
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, tbl[k].start, tbl[k].abort, tbl[k].valid, tbl[k].j,
            rhist(1'b0), rmax(), P*I'($urandom()), P'($urandom()));
      chk($sformatf("row%0d_busy", k),  HW'(busy),  HW'(tbl[k].busy));
      chk($sformatf("row%0d_done", k),  HW'(done),  HW'(tbl[k].done));
      chk($sformatf("row%0d_ready", k), HW'(ready), HW'(tbl[k].ready));
      chk($sformatf("row%0d_beat", k),  HW'(beat),  HW'(tbl[k].valid & tbl[k].ready));
      chk($sformatf("row%0d_cnt", k),   HW'(bcnt),  HW'(tbl[k].cnt));
      advance();
    end

    // J=4 with in_valid toggling: four commits, histogram equals last accepted nxt.
    drive(1'b0, 1'b1, 1'b0, 1'b0, W'(4), '0, '0, '0, '0);
    advance();
    nbeats = 0; seen = 0; last_h = '0;
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 1'b0, 1'b0, (k % 2 == 0), '0, rhist(1'b1), rmax(), P*I'($urandom()), P'($urandom()));
      if (done) begin
        seen = 1;
        advance();
        break;
      end
      if (beat) begin
        nbeats++;
        last_h = hn;
      end
      advance();
    end
    chk("tog_done_seen", HW'(seen),   HW'(1));
    chk("tog_beats",     HW'(nbeats), HW'(4));
    chk("tog_cnt",       HW'(bcnt),   HW'(4));
    chk("tog_hist",      hq,          last_h);
    idle_cycle();

    // Per-lane update: only lane 0 takes max/mode.
    drive(1'b0, 1'b1, 1'b0, 1'b0, W'(1), '0, '0, '0, '0); advance();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, rhist(1'b1), {16'd9, 16'd5}, {8'h80, 8'h04}, 2'b01);
    chk("lane_beat", HW'(beat), HW'(1));
    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    chk("lane_done", HW'(done), HW'(1));
    chk("lane_mode", HW'(moq),  HW'({8'h00, 8'h04}));
    chk("lane_max",  HW'(mq),   HW'({16'd0, 16'd5}));
    advance();

    // Saturation: all-ones followed by a wrapped-to-zero nxt holds all-ones.
    drive(1'b0, 1'b1, 1'b0, 1'b0, W'(2), '0, '0, '0, '0); advance();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, {HW{1'b1}}, {(P*W){1'b1}}, 16'h0102, 2'b11); advance();
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0, 16'h0201, 2'b11); advance();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    chk("sat_done", HW'(done), HW'(1));
    chk("sat_hist", hq,        {HW{1'b1}});
    chk("sat_max",  HW'(mq),   HW'({(P*W){1'b1}}));
    chk("sat_mode", HW'(moq),  HW'(16'h0201));
    advance();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 1) == 1),
            W'($urandom_range(0, 6)),
            rhist(1'b0), rmax(), P*I'($urandom()), P'($urandom()));
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
